// File: rtl/dmem_banked_pkg.sv
// Shared definitions for the banked byte-addressable data memory.
// Holds the access-size encodings and the control FSM state type.
package dmem_banked_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_banked_byte_bank.sv
// Single-port 8-bit synchronous RAM with registered read data.
// Read data holds its last value until the next read.
module byte_bank #(
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               i_en,
   input  logic               i_we,
   input  logic [DEPTH_W-1:0] i_addr,
   input  logic [7:0]         i_wdata,
   output logic [7:0]         o_rdata
);

   logic [7:0] r_mem [2**DEPTH_W];
   logic [7:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_banked.sv
// Byte-banked data memory: misaligned accesses that straddle a word boundary
// finish in one bank cycle because each bank gets its own word address.
module dmem_banked
   import dmem_banked_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int DEPTH_W = 10
) (
   input  logic               clk_20M,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_addr,
   input  logic               req_we,
   input  logic [1:0]         req_size,
   input  logic               req_unsigned,
   input  logic [8*LANES-1:0] req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [8*LANES-1:0] rsp_rdata,
   output logic               rsp_err,
   output logic [1:0]         dbg_state
);

   localparam int LB = $clog2(LANES);
   localparam int W  = 8 * LANES;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LB-1:0]      r_lane;
   logic [LB:0]        r_nbytes;
   logic               r_unsigned;
   logic [W-1:0]       r_rdata;
   logic               r_err;

   logic [LB-1:0]      w_lane;
   logic [DEPTH_W-1:0] w_word;
   logic [LB:0]        w_nbytes;
   logic [LB+1:0]      w_end;
   logic               w_wrap;
   logic               w_err;
   logic               w_accept;
   logic               w_do_bank;
   logic [W-1:0]       w_fmt;
   logic               w_sign;

   logic               w_bank_en    [LANES];
   logic               w_bank_we    [LANES];
   logic [DEPTH_W-1:0] w_bank_addr  [LANES];
   logic [7:0]         w_bank_wdata [LANES];
   logic [7:0]         w_bank_rdata [LANES];

   assign w_lane   = req_addr[LB-1:0];
   assign w_word   = req_addr[LB+DEPTH_W-1:LB];
   assign w_nbytes = (LB+1)'(1) << req_size;
   assign w_end    = (LB+2)'(w_lane) + (LB+2)'(w_nbytes);
   assign w_wrap   = w_end > (LB+2)'(LANES);

   // The top word has no successor: a wrapping access there is rejected.
   assign w_err = ({30'd0, req_size} > 32'(LB))
                || ((req_addr >> (LB + DEPTH_W)) != 32'd0)
                || (w_wrap && (&w_word));

   assign w_accept  = (r_state == ST_IDLE) && req_valid && !rst;
   assign w_do_bank = w_accept && !w_err;

   for (genvar g = 0; g < LANES; g++) begin : g_bank
      logic [LB-1:0] w_k;

      assign w_k             = LB'(g) - w_lane;
      assign w_bank_addr[g]  = ((LB'(g) < w_lane) && w_wrap) ? w_word + DEPTH_W'(1) : w_word;
      assign w_bank_we[g]    = w_do_bank && req_we && ({1'b0, w_k} < w_nbytes);
      assign w_bank_en[g]    = w_do_bank && (!req_we || w_bank_we[g]);
      assign w_bank_wdata[g] = req_wdata[{w_k, 3'b000} +: 8];

      byte_bank #(.DEPTH_W(DEPTH_W)) u_bank (
         .clk     (clk_20M),
         .i_en    (w_bank_en[g]),
         .i_we    (w_bank_we[g]),
         .i_addr  (w_bank_addr[g]),
         .i_wdata (w_bank_wdata[g]),
         .o_rdata (w_bank_rdata[g])
      );
   end

   // Rotate bank outputs back into request byte order, then extend.
   always_comb begin
      w_fmt  = '0;
      w_sign = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if ((LB+1)'(k) < r_nbytes) begin
            w_fmt[8*k +: 8] = w_bank_rdata[r_lane + LB'(k)];
         end
         if ((LB+1)'(k) + (LB+1)'(1) == r_nbytes) begin
            w_sign = w_bank_rdata[r_lane + LB'(k)][7];
         end
      end
      for (int k = 0; k < LANES; k++) begin
         if (!((LB+1)'(k) < r_nbytes)) begin
            w_fmt[8*k +: 8] = {8{w_sign & ~r_unsigned}};
         end
      end
   end

   always_ff @(posedge clk_20M) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = (req_we || w_err) ? ST_RESP : ST_READ;
            end
         end
         ST_READ: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_20M) begin
      if (rst) begin
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_lane     <= '0;
         r_nbytes   <= '0;
         r_unsigned <= 1'b0;
      end else if (w_accept) begin
         r_lane     <= w_lane;
         r_nbytes   <= w_nbytes;
         r_unsigned <= req_unsigned;
         r_rdata    <= '0;
         r_err      <= w_err;
      end else if (r_state == ST_READ) begin
         r_rdata <= w_fmt;
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign dbg_state = r_state;

endmodule

// File: doc/dmem_banked.md
DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 Parameter LANES, default 4: byte lanes per word; power of two, at least 2.
REQ-002 Parameter DEPTH_W, default 10: word-index width; memory holds 2^DEPTH_W words, i.e. LANES*2^DEPTH_W bytes.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_20M  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_size  in  2  log2 of access bytes (0 = byte, 1 = half, 2 = word).
REQ-011 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata  in  8*LANES  store data, right-aligned.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-015 rsp_rdata  out  8*LANES  load data, right-aligned and extended; 0 for stores and errors.
REQ-016 rsp_err  out  1  access rejected.

Function
REQ-017 Decode: lane = addr[log2(LANES)-1:0]; word = next DEPTH_W bits; nbytes = 2^req_size.
REQ-018 Storage is LANES independent 8-bit banks; bank i receives word+1 if i < lane and the access wraps past lane LANES-1, otherwise word.
REQ-019 Misaligned accesses that cross a word boundary SHALL complete in a single bank cycle using per-bank addresses (REQ-018).
REQ-020 Store: byte k of req_wdata goes to bank (lane+k) mod LANES for k < nbytes; no other bank is written.
REQ-021 Load: byte k of the result comes from bank (lane+k) mod LANES; bits above 8*nbytes are filled with the MSB of the loaded data unless req_unsigned=1, in which case they are filled with 0.
REQ-022 rsp_err=1 when req_size > log2(LANES), when any req_addr bit above the decoded range is nonzero, or when word+1 is needed and word = 2^DEPTH_W-1 (no wrap-around to word 0).
REQ-023 An erroring request SHALL write no bank, and its response SHALL carry rsp_rdata = 0.
REQ-024 FSM states:
- IDLE: req_ready=1. Accepting a valid load goes to READ. Accepting a store or any error goes to RESP.
- READ: banks output registered data. Next edge: format the data into the response register and go to RESP.
- RESP: rsp_valid=1. Go to IDLE on rsp_ready.
REQ-025 Latency: a store or error accepted at edge N gives rsp_valid at N+1; a load accepted at edge N gives rsp_valid at N+2.
REQ-026 req_ready=1 only in IDLE; no new request is accepted in the same cycle a response is consumed.
REQ-027 While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err SHALL stay stable.
REQ-028 Bank data and write enables are computed from the request only in the acceptance cycle; request inputs are ignored in all other cycles.

Reset
REQ-029 On rst the FSM goes to IDLE and outputs reset to req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset mid-operation (READ or RESP) drops the pending response; bank contents are not cleared and no partial write occurs after reset.

Structure
REQ-031 A shared package holds the req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-032 One sub-module, byte_bank, is a single-port 8-bit synchronous RAM (2^DEPTH_W entries, registered read), instantiated LANES times via generate.

Verification (LANES=4, DEPTH_W=10)
REQ-033 Store word 0x11223344 @0x10; load signed byte @0x13 -> 0x00000011; load half @0x12 -> 0x00001122; the load response arrives 2 cycles after acceptance.
REQ-034 Store half 0xBEEF @0x0B -> byte 0x0B=0xEF, byte 0x0C=0xBE, neighbouring bytes unchanged; load unsigned half @0x0B -> 0x0000BEEF in one bank cycle.
REQ-035 Store byte 0x80 @0x20; signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Word store @0x1000 -> rsp_err=1, rdata 0, nothing written; half load @0xFFF -> rsp_err=1; req_size=3 -> rsp_err=1.
REQ-037 Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; the next request is accepted only after the handshake.
REQ-038 Assert rst in READ -> next cycle rsp_valid=0, req_ready=1; a subsequent load returns pre-reset memory contents.
